// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Multi-cycle load/store sequencer between the datapath and the
//            data memory. It latches a request, drives the memory address,
//            write enable and write data, and waits out the memory read
//            latency. On a load it hands the read data to the MDR one cycle
//            before the Done pulse.
// Options  : `define MEM_BOUNDS_CHECK_EN enables an address range check
//            against DEPTH. An out-of-range request finishes with Err and Done
//            and performs no memory or MDR write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
   parameter int W      = 8,
   parameter int A      = 8,
   parameter int RD_LAT = 1,
   parameter int DEPTH  = 256
) (
   input  logic         Clk_i,
   input  logic         Reset_i,
   input  logic         Start_i,
   input  logic         IsLoad_i,
   input  logic [A-1:0] Addr_i,
   input  logic [W-1:0] StoreData_i,
   output logic [A-1:0] MemAddr_o,
   output logic         MemWrEn_o,
   output logic [W-1:0] MemWrData_o,
   input  logic [W-1:0] MemRdData_i,
   output logic         MdrWrEn_o,
   output logic [W-1:0] MdrData_o,
   output logic         Busy_o,
   output logic         Done_o,
   output logic         Err_o
);

   // Width of the read-latency counter; it must hold the value RD_LAT.
   localparam int CW = $clog2(RD_LAT + 1);

   localparam logic [CW-1:0] C_CNT_LOAD = CW'(RD_LAT);
   localparam logic [CW-1:0] C_CNT_LAST = CW'(1);

   // The address is zero-extended by one bit so DEPTH == 2**A still fits.
   localparam logic [A:0] C_DEPTH = (A + 1)'(DEPTH);

`ifdef MEM_BOUNDS_CHECK_EN
   localparam logic C_BOUNDS_EN = 1'b1;
`else
   localparam logic C_BOUNDS_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q;
   logic [A-1:0]    addr_q;
   logic [W-1:0]    data_q;
   logic            load_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;

   logic            w_oob;
   logic            w_mdr_fire;

   // Out-of-range request detection; constant 0 when the check is disabled.
   assign w_oob = C_BOUNDS_EN & ({1'b0, Addr_i} >= C_DEPTH);

   // Sequencer: request capture, latency countdown and registered status flags.
   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         load_q  <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Start_i) begin
                  addr_q <= Addr_i;
                  data_q <= StoreData_i;
                  load_q <= IsLoad_i;
                  cnt_q  <= C_CNT_LOAD;
                  busy_q <= 1'b1;
                  if (w_oob) begin
                     // Rejected request: skip straight to completion.
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (IsLoad_i) begin
                     state_q <= S_READ;
                  end else begin
                     state_q <= S_WRITE;
                  end
               end
            end
            S_READ: begin
               cnt_q <= cnt_q - C_CNT_LAST;
               if (cnt_q == C_CNT_LAST) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_WRITE: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   // The MDR strobe is combinational so the MDR captures read data at the
   // end of the last latency cycle; Reset suppresses it in that same cycle.
   assign w_mdr_fire = (state_q == S_READ) && (cnt_q == C_CNT_LAST) && !Reset_i;

   assign MemAddr_o   = addr_q;
   assign MemWrData_o = data_q;
   assign MemWrEn_o   = (state_q == S_WRITE) && !Reset_i;
   assign MdrWrEn_o   = w_mdr_fire;
   assign MdrData_o   = w_mdr_fire ? MemRdData_i : '0;
   assign Busy_o      = busy_q;
   assign Done_o      = done_q;

`ifdef MEM_BOUNDS_CHECK_EN
   assign Err_o = err_q;
`else
   // The error flag can never be set without the range check.
   assign Err_o = 1'b0 & err_q & load_q;
`endif

`ifdef MEM_BOUNDS_CHECK_EN
   // load_q records the request type for debug visibility only.
   logic w_unused_load;
   assign w_unused_load = load_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl. A per-cycle vector
//            table covers reset, load, store, back-to-back and start-while-
//            busy behaviour. Hand sequences cover reset abort and the range
//            check (macro MEM_BOUNDS_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       ld;
   logic [7:0] addr;
   logic [7:0] sd;

   logic [7:0] maddr2, wdata2, rd2, mdrd2;
   logic       we2, mdr2, busy2, done2, err2;
   logic [7:0] maddr3, wdata3, rd3, mdrd3;
   logic       we3, mdr3, busy3, done3, err3;

   logic [7:0] mem [256];

   int checks   = 0;
   int failures = 0;

   // Memory model: read data follows the driven address.
   assign rd2 = mem[maddr2];
   assign rd3 = mem[maddr3];

   mem_access_ctrl #(.W(8), .A(8), .RD_LAT(2), .DEPTH(128)) u_dut (
      .Clk_i(clk), .Reset_i(rst), .Start_i(start), .IsLoad_i(ld),
      .Addr_i(addr), .StoreData_i(sd), .MemAddr_o(maddr2), .MemWrEn_o(we2),
      .MemWrData_o(wdata2), .MemRdData_i(rd2), .MdrWrEn_o(mdr2),
      .MdrData_o(mdrd2), .Busy_o(busy2), .Done_o(done2), .Err_o(err2)
   );

   mem_access_ctrl #(.W(8), .A(8), .RD_LAT(3), .DEPTH(128)) u_dut3 (
      .Clk_i(clk), .Reset_i(rst), .Start_i(start), .IsLoad_i(ld),
      .Addr_i(addr), .StoreData_i(sd), .MemAddr_o(maddr3), .MemWrEn_o(we3),
      .MemWrData_o(wdata3), .MemRdData_i(rd3), .MdrWrEn_o(mdr3),
      .MdrData_o(mdrd3), .Busy_o(busy3), .Done_o(done3), .Err_o(err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, start, ld;
      logic [7:0] addr, sd;
      logic       busy, done, we, mdr;
      logic [7:0] mdrd, maddr, wdata;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Apply inputs for one cycle (away from the rising edge), then settle.
   task automatic drive(input logic r, input logic s, input logic l,
                        input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      rst = r; start = s; ld = l; addr = a; sd = d;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'hA5;
      mem[8'h20] = 8'hC3;
      mem[8'h7F] = 8'h3E;
      mem[8'h80] = 8'h77;

      rst = 1'b1; start = 1'b0; ld = 1'b0; addr = 8'h00; sd = 8'h00;

      //            rst start ld addr   sd     busy done we mdr mdrd   maddr  wdata
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      // load 0x10
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 8'h00};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h10, 8'h00};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 8'h00};
      // store 0x3C <- 0x5A, accepted right after DONE
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 8'h00};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 8'h5A};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h5A};
      // load 0x20 with a store request pulsed while busy
      vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h20, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h5A};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 8'h11};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 8'h20, 8'h11};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 8'h11};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 8'h11};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 8'h11};

      // One reset edge so the first table row starts from a known state.
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].rst, vecs[i].start, vecs[i].ld, vecs[i].addr, vecs[i].sd);
         chk($sformatf("row%0d busy", i),  {7'd0, busy2}, {7'd0, vecs[i].busy});
         chk($sformatf("row%0d done", i),  {7'd0, done2}, {7'd0, vecs[i].done});
         chk($sformatf("row%0d memwe", i), {7'd0, we2},   {7'd0, vecs[i].we});
         chk($sformatf("row%0d mdrwe", i), {7'd0, mdr2},  {7'd0, vecs[i].mdr});
         chk($sformatf("row%0d mdrd", i),  mdrd2,  vecs[i].mdrd);
         chk($sformatf("row%0d maddr", i), maddr2, vecs[i].maddr);
         chk($sformatf("row%0d wdata", i), wdata2, vecs[i].wdata);
         chk($sformatf("row%0d err", i),   {7'd0, err2},  8'h00);
      end

      // RD_LAT=3 load, undisturbed.
      drive(1'b0, 1'b1, 1'b1, 8'h10, 8'h00);
      chk("l3 idle busy", {7'd0, busy3}, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("l3 c1 busy", {7'd0, busy3}, 8'h01);
      chk("l3 c1 mdrwe", {7'd0, mdr3}, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("l3 c2 mdrwe", {7'd0, mdr3}, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("l3 c3 mdrwe", {7'd0, mdr3}, 8'h01);
      chk("l3 c3 mdrd", mdrd3, 8'hA5);
      chk("l3 c3 done", {7'd0, done3}, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("l3 c4 done", {7'd0, done3}, 8'h01);
      chk("l3 c4 mdrwe", {7'd0, mdr3}, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("l3 c5 busy", {7'd0, busy3}, 8'h00);
      chk("l3 c5 done", {7'd0, done3}, 8'h00);

      // RD_LAT=3 load aborted by Reset in the cnt==1 cycle.
      drive(1'b0, 1'b1, 1'b1, 8'h10, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("abort c2 busy", {7'd0, busy3}, 8'h01);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("abort c3 mdrwe", {7'd0, mdr3}, 8'h00);
      chk("abort c3 mdrd", mdrd3, 8'h00);
      chk("abort c3 done", {7'd0, done3}, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("abort c4 busy", {7'd0, busy3}, 8'h00);
      chk("abort c4 done", {7'd0, done3}, 8'h00);
      chk("abort c4 maddr", maddr3, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("abort c5 done", {7'd0, done3}, 8'h00);
      chk("abort c5 mdrwe", {7'd0, mdr3}, 8'h00);

`ifdef MEM_BOUNDS_CHECK_EN
      // Out-of-range load is rejected with Err alongside Done.
      drive(1'b0, 1'b1, 1'b1, 8'h80, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("oob c1 done", {7'd0, done2}, 8'h01);
      chk("oob c1 err", {7'd0, err2}, 8'h01);
      chk("oob c1 mdrwe", {7'd0, mdr2}, 8'h00);
      chk("oob c1 memwe", {7'd0, we2}, 8'h00);
      // Last valid address loads normally.
      drive(1'b0, 1'b1, 1'b1, 8'h7F, 8'h00);
      chk("oob c2 err", {7'd0, err2}, 8'h00);
      chk("oob c2 busy", {7'd0, busy2}, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("inb c1 err", {7'd0, err2}, 8'h00);
      chk("inb c1 done", {7'd0, done2}, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("inb c2 mdrwe", {7'd0, mdr2}, 8'h01);
      chk("inb c2 mdrd", mdrd2, 8'h3E);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("inb c3 done", {7'd0, done2}, 8'h01);
      chk("inb c3 err", {7'd0, err2}, 8'h00);
`else
      // Without the check, address 0x80 is an ordinary load.
      drive(1'b0, 1'b1, 1'b1, 8'h80, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("nochk c1 done", {7'd0, done2}, 8'h00);
      chk("nochk c1 err", {7'd0, err2}, 8'h00);
      chk("nochk c1 busy", {7'd0, busy2}, 8'h01);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("nochk c2 mdrwe", {7'd0, mdr2}, 8'h01);
      chk("nochk c2 mdrd", mdrd2, 8'h77);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("nochk c3 done", {7'd0, done2}, 8'h01);
      chk("nochk c3 err", {7'd0, err2}, 8'h00);
`endif

      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("final busy", {7'd0, busy2}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle sequencer for load/store instructions; sits between the datapath and the data memory.
- Drives the data-memory address, write enable and write data.
- On loads, captures the memory read data and drives the write enable and data inputs of the downstream memory data register (MDR) one cycle before Done.
- Decouples datapath timing from data-memory read latency.

Parameters:
- W, 8, data path width.
- A, 8, address width.
- RD_LAT, 1, data-memory read latency in cycles (≥1); MemRdData is valid RD_LAT cycles after MemAddr is stable.
- DEPTH, 256, number of valid memory locations (used only under the optional feature).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request strobe; sampled only in IDLE.
- IsLoad  in  1  1 = load, 0 = store; sampled with Start.
- Addr  in  A  access address; sampled with Start.
- StoreData  in  W  store data; sampled with Start.
- MemAddr  out  A  address to data memory.
- MemWrEn  out  1  data-memory write enable.
- MemWrData  out  W  data-memory write data.
- MemRdData  in  W  data-memory read data.
- MdrWrEn  out  1  write enable to MDR.
- MdrData  out  W  data to MDR.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle error pulse, coincident with Done.

Behaviour:
- Registers:
  - state
  - addr_q[A], data_q[W], load_q
  - cnt, width clog2(RD_LAT+1)
- Reset:
  - Synchronous; takes priority over everything.
  - state=IDLE; addr_q, data_q, load_q, cnt cleared to 0.
  - MemWrEn and MdrWrEn are forced 0 in any cycle where Reset is high, regardless of state.
  - Reset mid-operation aborts the access: no MDR write, no Done.
- Outputs:
  - MemAddr=addr_q in all states; reset value 0.
  - MemWrData=data_q; reset value 0.
  - Busy, Done, Err, MdrData: reset value 0.
- IDLE:
  - Busy=0.
  - On Start=1: latch Addr/StoreData/IsLoad; cnt<=RD_LAT.
  - Next state is READ if IsLoad, else WRITE.
  - Start=0: stay.
- READ:
  - cnt decrements each cycle.
  - When cnt==1:
    - MdrWrEn=1 and MdrData=MemRdData, combinationally in that cycle, so the MDR loads at the end of that cycle.
    - Next state DONE.
  - MdrData=0 whenever MdrWrEn=0.
- WRITE:
  - MemWrEn=1 for exactly this one cycle.
  - Next state DONE.
- DONE:
  - Done=1 for one cycle; next state IDLE.
- Start handling:
  - Start in READ/WRITE/DONE is ignored, not queued.
  - A new request can be accepted in the cycle after DONE.
- Latency:
  - Load accepted at edge k: MDR holds the data after edge k+RD_LAT+1; Done is high during cycle k+RD_LAT+1.
  - Store accepted at edge k: memory written at edge k+2; Done during cycle k+2.
- Throughput:
  - Load: one access per RD_LAT+2 cycles.
  - Store: one access per 3 cycles.
- Addr/StoreData changes after acceptance have no effect; latched copies are used.

Optional Feature:
- Macro MEM_BOUNDS_CHECK_EN.
- Defined:
  - In IDLE with Start=1 and Addr ≥ DEPTH: go directly to DONE.
  - No MemWrEn or MdrWrEn pulse; Err=1 together with Done for one cycle.
- Undefined:
  - No check is performed; Err is tied to 0.
  - DEPTH is unused.

Test Plan:
- Reset: hold Reset 2 cycles with Start=1, IsLoad=0 → MemWrEn=0, Busy=0, Done=0, MemAddr=0 throughout; IDLE afterwards.
- Load, RD_LAT=2: memory[0x10]=0xA5; Start, IsLoad=1, Addr=0x10 at edge k.
  - MdrWrEn=1 with MdrData=0xA5 in cycle k+2 only.
  - Done in cycle k+3.
  - Busy high in cycles k+1..k+3.
- Store: Start, IsLoad=0, Addr=0x3C, StoreData=0x5A at edge k.
  - MemWrEn=1 in cycle k+1 only, with MemAddr=0x3C and MemWrData=0x5A.
  - Done in cycle k+2; MdrWrEn never asserted.
- Start while busy: during a load, pulse Start with IsLoad=0, Addr=0x01 → ignored; no MemWrEn; MemAddr stays at the load address until IDLE.
- Reset mid-load, RD_LAT=3: assert Reset in the cycle where cnt==1 → MdrWrEn=0 that cycle; no Done; state IDLE after the edge.
- MEM_BOUNDS_CHECK_EN, DEPTH=128: load at Addr=0x80 → no MdrWrEn; Done=1 and Err=1 in cycle k+1. Addr=0x7F → normal load, Err=0.
